// File: rtl/four_bits_down_counter.sv
// Loadable down-counter/timer with prescaler and one-cycle underflow pulse.
// Define AUTO_RELOAD_EN to reload the captured start value on terminal count (periodic mode).
module four_bits_down_counter #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] counter,
  output logic             underflow,
  output logic             busy,
  output logic             state_dbg
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_MAX = PW'(PRESCALE - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] counter_q, counter_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             underflow_q, underflow_d;
`ifdef AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  // Priority per edge: load > stop > start > tick.
  always_comb begin
    state_d     = state_q;
    counter_d   = counter_q;
    pre_d       = pre_q;
    underflow_d = 1'b0;
`ifdef AUTO_RELOAD_EN
    reload_d    = reload_q;
`endif
    if (load) begin
      counter_d = load_value;
      pre_d     = '0;
      state_d   = IDLE;
`ifdef AUTO_RELOAD_EN
      reload_d  = load_value;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start && (counter_q != '0)) begin
            state_d = RUN;
            pre_d   = '0;
          end
        end
        RUN: begin
          if (stop) begin
            state_d = IDLE;
            pre_d   = '0;
          end else if (pre_q == PS_MAX) begin
            pre_d = '0;
            if (counter_q > WIDTH'(1)) begin
              counter_d = counter_q - WIDTH'(1);
            end else if (counter_q == WIDTH'(1)) begin
              underflow_d = 1'b1;
`ifdef AUTO_RELOAD_EN
              counter_d   = reload_q;
`else
              counter_d   = '0;
              state_d     = IDLE;
`endif
            end else begin
              // Running at zero cannot normally happen; park safely without a pulse.
              state_d = IDLE;
            end
          end else begin
            pre_d = pre_q + PW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      counter_q   <= '0;
      pre_q       <= '0;
      underflow_q <= 1'b0;
`ifdef AUTO_RELOAD_EN
      reload_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      counter_q   <= counter_d;
      pre_q       <= pre_d;
      underflow_q <= underflow_d;
`ifdef AUTO_RELOAD_EN
      reload_q    <= reload_d;
`endif
    end
  end

  assign counter   = counter_q;
  assign underflow = underflow_q;
  assign busy      = (state_q == RUN);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_four_bits_down_counter.sv
// Directed bench for four_bits_down_counter: one instance at PRESCALE=1, one at PRESCALE=3.
// Handshake: load/start/stop are level inputs sampled on each rising edge; no ready side.
module tb_four_bits_down_counter;

  logic       clk;
  logic       reset;
  logic       load, start, stop;
  logic [3:0] load_value;
  logic [3:0] counter;
  logic       underflow, busy, state_dbg;

  logic       load3, start3, stop3;
  logic [3:0] load_value3;
  logic [3:0] counter3;
  logic       underflow3, busy3, state_dbg3;

  int n_tests = 0;
  int n_fail  = 0;

  four_bits_down_counter #(.WIDTH(4), .PRESCALE(1)) dut (
    .clk(clk), .reset(reset), .load(load), .load_value(load_value),
    .start(start), .stop(stop), .counter(counter), .underflow(underflow),
    .busy(busy), .state_dbg(state_dbg)
  );

  four_bits_down_counter #(.WIDTH(4), .PRESCALE(3)) dut3 (
    .clk(clk), .reset(reset), .load(load3), .load_value(load_value3),
    .start(start3), .stop(stop3), .counter(counter3), .underflow(underflow3),
    .busy(busy3), .state_dbg(state_dbg3)
  );

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_main(input string tag, input int c, input int u, input int b);
    chk({tag, ".counter"}, 32'(counter), 32'(c));
    chk({tag, ".underflow"}, 32'(underflow), 32'(u));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
  endtask

  task automatic do_load(input logic [3:0] v);
    load = 1'b1; load_value = v;
    step();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    int uf_at;
    reset = 1'b0;
    load = 0; start = 0; stop = 0; load_value = '0;
    load3 = 0; start3 = 0; stop3 = 0; load_value3 = '0;
    step(); step();
    chk_main("reset", 0, 0, 0);
    chk("reset.state_dbg", 32'(state_dbg), 0);
    chk("reset3.counter", 32'(counter3), 0);
    #2 reset = 1'b1;
    step();

    // Start with counter 0 is ignored.
    do_start();
    chk_main("start_zero", 0, 0, 0);

`ifndef AUTO_RELOAD_EN
    // One-shot, PRESCALE=1: load 5, count 4..0, single pulse after E5.
    do_load(4'd5);
    chk_main("load5", 5, 0, 0);
    do_start();
    chk_main("start5", 5, 0, 1);
    for (int i = 1; i <= 5; i++) begin
      step();
      chk_main($sformatf("oneshot_e%0d", i), 5 - i, (i == 5) ? 1 : 0, (i < 5) ? 1 : 0);
    end
    step();
    chk_main("oneshot_after", 0, 0, 0);

    // Stop after 3 ticks, then resume to underflow.
    do_load(4'd8);
    do_start();
    step(); step(); step();
    chk_main("pre_stop", 5, 0, 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk_main("stopped", 5, 0, 0);
    step();
    chk_main("stopped_hold", 5, 0, 0);
    do_start();
    for (int i = 1; i <= 5; i++) begin
      step();
      chk_main($sformatf("resume_e%0d", i), 5 - i, (i == 5) ? 1 : 0, (i < 5) ? 1 : 0);
    end

    // Load 15: underflow after exactly 15 ticks, no wrap afterwards.
    do_load(4'hF);
    do_start();
    uf_at = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (underflow === 1'b1 && uf_at < 0) uf_at = i;
    end
    chk("f_latency", 32'(uf_at), 32'd15);
    chk_main("f_nowrap", 0, 0, 0);
`else
    // Auto-reload: load 4 gives 3,2,1,4,... with a pulse every 4 cycles.
    do_load(4'd4);
    do_start();
    for (int i = 1; i <= 12; i++) begin
      step();
      chk_main($sformatf("auto_e%0d", i), ((i % 4) == 0) ? 4 : 4 - (i % 4),
               ((i % 4) == 0) ? 1 : 0, 1);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk_main("auto_stop", 4, 0, 0);
`endif

    // Load and start together: load wins, stays IDLE.
    load = 1'b1; load_value = 4'd3; start = 1'b1;
    step();
    load = 1'b0; start = 1'b0;
    chk_main("load_start", 3, 0, 0);
    step();
    chk_main("load_start_hold", 3, 0, 0);

    // Stop and start together in RUN: stop wins.
    do_start();
    step();
    chk_main("run_before_stop", 2, 0, 1);
    stop = 1'b1; start = 1'b1;
    step();
    stop = 1'b0; start = 1'b0;
    chk_main("stop_start", 2, 0, 0);

    // Load mid-count aborts without a pulse.
    do_start();
    step();
    chk_main("pre_abort", 1, 0, 1);
    do_load(4'd7);
    chk_main("abort", 7, 0, 0);

    // PRESCALE=3: load 2, decrements at E3 and E6, pulse after E6.
    load3 = 1'b1; load_value3 = 4'd2;
    step();
    load3 = 1'b0;
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step();
`ifdef AUTO_RELOAD_EN
      chk($sformatf("ps3_e%0d.counter", i), 32'(counter3), (i < 3) ? 2 : (i < 6) ? 1 : 2);
      chk($sformatf("ps3_e%0d.busy", i), 32'(busy3), 1);
`else
      chk($sformatf("ps3_e%0d.counter", i), 32'(counter3), (i < 3) ? 2 : (i < 6) ? 1 : 0);
      chk($sformatf("ps3_e%0d.busy", i), 32'(busy3), (i < 6) ? 1 : 0);
`endif
      chk($sformatf("ps3_e%0d.underflow", i), 32'(underflow3), (i == 6) ? 1 : 0);
    end
    stop3 = 1'b1;
    step();
    stop3 = 1'b0;
    chk("ps3_end.underflow", 32'(underflow3), 0);
    chk("ps3_end.busy", 32'(busy3), 0);

    // Reset asserted between edges mid-run clears everything immediately.
    do_load(4'd9);
    do_start();
    step();
    chk_main("pre_reset", 8, 0, 1);
    reset = 1'b0;
    #1;
    chk_main("async_reset", 0, 0, 0);
    #2 reset = 1'b1;
    step();
    do_start();
    chk_main("post_reset_start", 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/four_bits_down_counter.md
Name: four_bits_down_counter

Overview:
Loadable down-counter/timer, the count-down counterpart of the free-running 4-bit up-counter with overflow. Software or a controlling FSM loads a start value, starts the count, and receives a one-cycle underflow pulse when the count reaches zero. The block also provides a prescaler for slow ticks and optional auto-reload for periodic events. It is used as the terminal-count/timeout source next to the up-counter in the counter test designs.

Parameters:
WIDTH, 4, counter and load value width in bits (min 2).
PRESCALE, 1, clock cycles per decrement tick (min 1); internal prescaler width = clog2(PRESCALE), min 1 bit.

Ports:
clk  input  1  single clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset (asserted at 0).
load  input  1  sampled each edge; when 1, load_value is captured.
load_value  input  WIDTH  value captured on load.
start  input  1  begin counting; honoured only in IDLE with counter != 0.
stop  input  1  halt counting; honoured only in RUN.
counter  output  WIDTH  current count (registered).
underflow  output  1  one-cycle pulse on terminal count.
busy  output  1  high while in RUN.

Behaviour:
- Reset (reset=0, asynchronous): counter=0, reload_reg=0, prescaler=0, state=IDLE, underflow=0, busy=0. Release is synchronous to the next clk edge.
- States: IDLE, RUN. busy = (state==RUN), registered, no combinational paths in to out.
- Priority per edge: load > stop > start > tick.
- load (any state): counter<=load_value, reload_reg<=load_value, prescaler<=0, state<=IDLE, underflow<=0. A load mid-count aborts the count without an underflow pulse.
- IDLE: counter holds.
  - start=1 with counter!=0: state<=RUN, prescaler<=0.
  - start=1 with counter==0: ignored, no pulse.
- RUN, stop=1: state<=IDLE, counter holds, prescaler<=0. start is ignored in RUN.
- Tick: RUN and prescaler==PRESCALE-1. Otherwise prescaler increments. On tick, prescaler<=0.
  - Tick with counter>1: counter<=counter-1.
  - Tick with counter==1 (terminal): counter<=0, underflow<=1 for exactly one cycle, state<=IDLE.
- underflow defaults to 0 every cycle it is not set. The counter never wraps below 0; no decrement occurs at 0.
- Latency: start accepted at edge E0. Terminal count is reached at edge E0 + N*PRESCALE for load value N. underflow is high in the cycle following that edge.
- Simultaneous load+start: load wins; start is dropped and a new start is required. Simultaneous stop+start in RUN: stop wins.

Optional Feature:
Macro AUTO_RELOAD_EN.
- Defined: on terminal tick, counter<=reload_reg instead of 0, underflow pulses, state stays RUN. Periodic pulses repeat every reload_reg*PRESCALE cycles until stop or load. If reload_reg==1, underflow is high on every tick.
- Undefined: one-shot behaviour as above; reload_reg may be optimised away.

Test Plan:
- Reset mid-run: load 9, start, assert reset=0 asynchronously between edges -> counter=0, busy=0, underflow=0 immediately. After release, start has no effect (counter 0).
- One-shot, PRESCALE=1: load 5, start at E0 -> counter 4,3,2,1,0 at E1..E5. underflow high only during the cycle after E5. busy falls at E5.
- Prescale, PRESCALE=3: load 2, start -> counter decrements at E3 and E6. Single underflow pulse after E6. Total 6 cycles.
- Stop/resume and priority:
  - load 8, start, stop after 3 ticks -> counter holds 5, busy=0.
  - start again -> continues 4..0 with one underflow.
  - load 3 and start in the same cycle -> counter=3, stays IDLE.
- Edge values: start with counter 0 -> no RUN, no pulse. load 15 (4'hF), start -> 15 cycles to underflow, no wrap to 15 afterwards.
- AUTO_RELOAD_EN: load 4, start -> underflow pulses every 4 cycles (3 observed). Counter sequence 3,2,1,4,3,... Stop then returns to IDLE with counter held.
